// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and register-file types for the CPU core.
package cpu_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 3;
   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: asynchronous register-file read mux with optional write-through bypass.
module regfile_read_port #(
   parameter int DATA_W        = cpu_pkg::DATA_W,
   parameter int ADDR_W        = cpu_pkg::REG_ADDR_W,
   parameter bit WRITE_THROUGH = 1'b0
) (
   input  logic [DATA_W-1:0] i_regs [0:(1<<ADDR_W)-1],
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_data
);
   logic w_bypass;
   always_comb begin
      w_bypass = WRITE_THROUGH && i_we && (i_waddr == i_addr);
      o_data   = w_bypass ? i_wdata : i_regs[i_addr];
   end
endmodule

// File: rtl/register_file.sv
// register_file: 8x32 general-purpose registers, two async read ports, one sync write port.
module register_file #(
   parameter int DATA_W        = cpu_pkg::DATA_W,
   parameter int ADDR_W        = cpu_pkg::REG_ADDR_W,
   parameter bit WRITE_THROUGH = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] readAddr1,
   input  logic [ADDR_W-1:0] readAddr2,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic              writeEnable,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] registers [0:DEPTH-1];
   // Plain always block keeps hierarchical preloads from a bench legal.
   always @(posedge clk) begin
      if (rst)
         for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
      else if (writeEnable)
         registers[writeAddr] <= writeData;
   end
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(WRITE_THROUGH)) u_rp1 (
      .i_regs(registers), .i_addr(readAddr1), .i_we(writeEnable),
      .i_waddr(writeAddr), .i_wdata(writeData), .o_data(readData1)
   );
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_THROUGH(WRITE_THROUGH)) u_rp2 (
      .i_regs(registers), .i_addr(readAddr2), .i_we(writeEnable),
      .i_waddr(writeAddr), .i_wdata(writeData), .o_data(readData2)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of both write-through variants of register_file.
module tb_register_file;
   import cpu_pkg::*;
   logic      clk = 1'b0;
   logic      rst = 1'b0;
   reg_addr_t ra1 = '0, ra2 = '0, wa = '0;
   logic      we = 1'b0;
   word_t     wd = '0;
   word_t     rd1_0, rd2_0, rd1_1, rd2_1;
   int        errors = 0;
   int        checks = 0;

   always #5 clk = ~clk;

   register_file #(.WRITE_THROUGH(1'b0)) dut0 (
      .clk(clk), .rst(rst), .readAddr1(ra1), .readAddr2(ra2), .writeAddr(wa),
      .writeEnable(we), .writeData(wd), .readData1(rd1_0), .readData2(rd2_0)
   );
   register_file #(.WRITE_THROUGH(1'b1)) dut1 (
      .clk(clk), .rst(rst), .readAddr1(ra1), .readAddr2(ra2), .writeAddr(wa),
      .writeEnable(we), .writeData(wd), .readData1(rd1_1), .readData2(rd2_1)
   );

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         dut0.registers[i] = word_t'(10 * (i + 1));
         dut1.registers[i] = word_t'(10 * (i + 1));
      end
      ra1 = 3'd3; ra2 = 3'd2;
      #1;
      chk("preload_rd1_wt0", rd1_0, 32'd40);
      chk("preload_rd2_wt0", rd2_0, 32'd30);
      chk("preload_rd1_wt1", rd1_1, 32'd40);
      chk("preload_rd2_wt1", rd2_1, 32'd30);

      wa = 3'd5; wd = 32'd100; we = 1'b1;
      edge_step();
      we = 1'b0; ra1 = 3'd5; ra2 = 3'd2;
      #1;
      chk("write5_rd1_wt0", rd1_0, 32'd100);
      chk("write5_rd2_wt0", rd2_0, 32'd30);
      chk("write5_rd1_wt1", rd1_1, 32'd100);

      wa = 3'd4; wd = 32'hDEADBEEF; we = 1'b0;
      repeat (3) edge_step();
      ra1 = 3'd4; ra2 = 3'd4;
      #1;
      chk("no_we_rd1_wt0", rd1_0, 32'd50);
      chk("no_we_rd2_wt1", rd2_1, 32'd50);

      ra1 = 3'd6; ra2 = 3'd6; wa = 3'd6; wd = 32'd7; we = 1'b1;
      #1;
      chk("hazard_pre_wt0", rd1_0, 32'd70);
      chk("hazard_pre_wt1_p1", rd1_1, 32'd7);
      chk("hazard_pre_wt1_p2", rd2_1, 32'd7);
      ra2 = 3'd5;
      #1;
      chk("hazard_other_addr_wt1", rd2_1, 32'd100);
      edge_step();
      we = 1'b0;
      #1;
      chk("hazard_post_wt0", rd1_0, 32'd7);
      chk("hazard_post_wt1", rd1_1, 32'd7);

      rst = 1'b1; we = 1'b1; wa = 3'd1; wd = 32'h55;
      edge_step();
      rst = 1'b0; we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra1 = reg_addr_t'(i); ra2 = reg_addr_t'(7 - i);
         #1;
         chk($sformatf("reset_rd1_wt0_a%0d", i), rd1_0, 32'd0);
         chk($sformatf("reset_rd2_wt0_a%0d", 7 - i), rd2_0, 32'd0);
         chk($sformatf("reset_rd1_wt1_a%0d", i), rd1_1, 32'd0);
      end

      wa = 3'd7; wd = 32'hFFFFFFFF; we = 1'b1;
      edge_step();
      wa = 3'd0; wd = 32'h1;
      edge_step();
      we = 1'b0; ra1 = 3'd7; ra2 = 3'd0;
      #1;
      chk("full_width_rd1_wt0", rd1_0, 32'hFFFFFFFF);
      chk("entry0_rd2_wt0", rd2_0, 32'h1);
      chk("full_width_rd1_wt1", rd1_1, 32'hFFFFFFFF);
      chk("entry0_rd2_wt1", rd2_1, 32'h1);
      ra1 = 3'd0; ra2 = 3'd7;
      #1;
      chk("swap_rd1_wt0", rd1_0, 32'h1);
      chk("swap_rd2_wt0", rd2_0, 32'hFFFFFFFF);
      ra1 = 3'd1;
      #1;
      chk("reset_dropped_write_wt0", rd1_0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
